stream_flush_initiator: RTL and testbench
=========================================

STREAM_FLUSH_INITIATOR -- requirements
Module: stream_flush_initiator

Interface
REQ-001 Parameter T, default logic: payload type.
REQ-002 Parameter FlushCycles, default 1: number of consecutive cycles flush_o is held; legal range 1..255.
REQ-003 Parameter DropCntWidth, default 8: width of drop_cnt_o; legal range 1..32.
REQ-004 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_i  input  1  reset; asynchronous, active-high.
REQ-006 clr_i  input  1  synchronous clear; same effect as reset, applied on the clock edge.
REQ-007 flush_req_i  input  1  flush request; level-sampled, acted on in IDLE only.
REQ-008 flush_busy_o  output  1  high while a flush is in progress or being accepted.
REQ-009 valid_i / ready_o / data_i  input / output / T  upstream handshake.
REQ-010 valid_o / ready_i / data_o  output / input / T  downstream handshake towards a flushable spill register.
REQ-011 flush_o  output  1  flush strobe towards the downstream spill register.
REQ-012 drop_cnt_o  output  DropCntWidth  saturating count of beats discarded by flushes.

Function
REQ-013 The block SHALL contain one output register (full_q, data_q) and an FSM with states IDLE and FLUSH.
REQ-014 In IDLE: valid_o=full_q, data_o=data_q, ready_o = !full_q || ready_i, flush_o=0.
REQ-015 In IDLE, an upstream handshake (valid_i && ready_o) SHALL load data_i into data_q and set full_q; the beat appears on valid_o one cycle later (latency 1).
REQ-016 In IDLE, a downstream handshake without a simultaneous upstream handshake SHALL clear full_q. Back-to-back beats SHALL sustain one beat per cycle.
REQ-017 Once valid_o is high, valid_o and data_o SHALL stay stable until the downstream handshake or entry into FLUSH.
REQ-018 Acceptance cycle (IDLE && flush_req_i): ready_o SHALL be 0, and valid_o/data_o SHALL remain as in REQ-014. A downstream handshake in this cycle completes normally. The FSM then moves to FLUSH.
REQ-019 If full_q is set at the acceptance cycle and no downstream handshake occurs, the beat SHALL be discarded: full_q cleared, drop_cnt_o incremented by 1.
REQ-020 In FLUSH: flush_o=1, valid_o=0, ready_o=0, and full_q stays 0. flush_o SHALL be high for exactly FlushCycles consecutive cycles, counted by an internal counter. After the last cycle the FSM returns to IDLE.
REQ-021 flush_o and valid_o SHALL never be high in the same cycle.
REQ-022 flush_req_i SHALL be ignored while in FLUSH; if it is still high on the first IDLE cycle, a new acceptance cycle SHALL start.
REQ-023 flush_busy_o = (state==FLUSH) || (state==IDLE && flush_req_i).
REQ-024 drop_cnt_o SHALL saturate at 2^DropCntWidth-1 with no wrap-around.
REQ-025 valid_i during FLUSH SHALL be ignored; no data is accepted and nothing is counted.

Reset
REQ-026 Reset and clr_i SHALL both put the block in this state: state=IDLE, full_q=0, data_q='0, flush counter=0, drop_cnt_o=0.
REQ-027 After reset the outputs SHALL be: valid_o=0, flush_o=0, flush_busy_o=0, ready_o=1.
REQ-028 Reset or clr_i asserted during FLUSH SHALL abort the flush immediately; flush_o is 0 in the next cycle.

Configuration
REQ-029 Macro STREAM_FLUSH_INITIATOR_DROP_CNT_EN defined: drop counter implemented per REQ-019 and REQ-024.
REQ-030 Macro undefined: the counter SHALL be absent and drop_cnt_o tied to '0; all other behaviour is unchanged.

Structure
REQ-031 The state enum (IDLE, FLUSH) and the FlushCycles counter-width constant SHALL live in shared package stream_flush_pkg.
REQ-032 The output register SHALL be a sub-module instance of stream_flush_initiator_reg (one entry, with load/clear controls); the FSM and the counters stay in the top module.

Verification
REQ-033 Streaming: 8 beats 0x01..0x08 with ready_i=1 throughout -> same 8 beats on data_o, each 1 cycle after input, no gaps, drop_cnt_o=0.
REQ-034 Stalled flush: beat 0xAA buffered, ready_i=0, flush_req_i pulsed 1 cycle -> ready_o=0 in the pulse cycle, then flush_o high 1 cycle with valid_o=0, drop_cnt_o=1, then IDLE with ready_o=1.
REQ-035 Race: beat 0x55 buffered, ready_i=1 in the acceptance cycle -> 0x55 delivered, drop_cnt_o stays 0, flush_o still pulses.
REQ-036 FlushCycles=4, flush_req_i held high for 10 cycles -> flush_o high for 4 cycles, low 1 cycle (acceptance), high for 4 cycles; never with valid_o.
REQ-037 DropCntWidth=2 and macro defined, 5 stalled flushes -> drop_cnt_o sequence 1,2,3,3,3. Macro undefined -> drop_cnt_o=0 throughout.
REQ-038 rst_i asserted asynchronously mid-FLUSH (FlushCycles=4, cycle 2) -> flush_o=0 and valid_o=0 immediately; ready_o=1 after release.

Source files
------------

// File: rtl/stream_flush_pkg.sv
// Shared types and constants for the stream flush initiator slice.
package stream_flush_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } flush_state_e;

    // Wide enough for the largest legal flush length (255 cycles).
    localparam int FlushCntWidth = 8;

endpackage

// File: rtl/stream_flush_initiator_reg.sv
// Single-entry output register with load and clear controls; load wins over clear.
module stream_flush_initiator_reg #(
    parameter type T = logic
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic load_i,
    input  logic clear_i,
    input  T     data_i,
    output logic full_o,
    output T     data_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_o <= 1'b0;
            data_o <= '0;
        end else if (clr_i) begin
            full_o <= 1'b0;
            data_o <= '0;
        end else if (load_i) begin
            full_o <= 1'b1;
            data_o <= data_i;
        end else if (clear_i) begin
            full_o <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_flush_initiator.sv
// Stream stage that issues a flush strobe to a downstream spill register and drops its own beat.
// Optional drop counter enabled by macro STREAM_FLUSH_INITIATOR_DROP_CNT_EN.
module stream_flush_initiator
    import stream_flush_pkg::*;
#(
    parameter type         T            = logic,
    parameter int unsigned FlushCycles  = 1,
    parameter int unsigned DropCntWidth = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clr_i,
    input  logic                    flush_req_i,
    output logic                    flush_busy_o,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  T                        data_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output T                        data_o,
    output logic                    flush_o,
    output logic [DropCntWidth-1:0] drop_cnt_o
);

    localparam logic [FlushCntWidth-1:0] LastCnt = FlushCntWidth'(FlushCycles - 1);

    flush_state_e             state;
    logic [FlushCntWidth-1:0] flush_cnt;
    logic                     full_q;
    T                         data_q;
    logic                     idle;
    logic                     accept;
    logic                     up_hs;
    logic                     down_hs;
    logic                     load;
    logic                     clear;

    // Upstream is blocked during the acceptance cycle so nothing new lands in a beat about to be flushed.
    assign idle         = (state == IDLE);
    assign accept       = idle && flush_req_i;
    assign ready_o      = idle && !flush_req_i && (!full_q || ready_i);
    assign valid_o      = idle && full_q;
    assign data_o       = data_q;
    assign flush_o      = (state == FLUSH);
    assign flush_busy_o = flush_o || accept;
    assign up_hs        = valid_i && ready_o;
    assign down_hs      = valid_o && ready_i;
    assign load         = up_hs;
    assign clear        = down_hs || (accept && full_q);

    stream_flush_initiator_reg #(
        .T(T)
    ) u_out_reg (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (clr_i),
        .load_i (load),
        .clear_i(clear),
        .data_i (data_i),
        .full_o (full_q),
        .data_o (data_q)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            flush_cnt <= '0;
        end else if (clr_i) begin
            state     <= IDLE;
            flush_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush_req_i) begin
                        state     <= FLUSH;
                        flush_cnt <= '0;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == LastCnt) begin
                        state     <= IDLE;
                        flush_cnt <= '0;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    flush_cnt <= '0;
                end
            endcase
        end
    end

`ifdef STREAM_FLUSH_INITIATOR_DROP_CNT_EN
    logic                    drop;
    logic [DropCntWidth-1:0] drop_cnt;

    // A buffered beat is lost only when the flush is accepted without a downstream handshake.
    assign drop = accept && full_q && !ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            drop_cnt <= '0;
        end else if (clr_i) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign drop_cnt_o = drop_cnt;
`else
    assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_stream_flush_initiator.sv
// Directed bench for stream_flush_initiator with a per-cycle reference model and literal spot checks.
module tb_stream_flush_initiator;

    localparam int FLUSH_CYCLES = 4;
    localparam int DROP_W       = 2;
    localparam int DROP_MAX     = (1 << DROP_W) - 1;
`ifdef STREAM_FLUSH_INITIATOR_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic              clk;
    logic              rst_i;
    logic              clr_i;
    logic              flush_req_i;
    logic              flush_busy_o;
    logic              valid_i;
    logic              ready_o;
    logic [7:0]        data_i;
    logic              valid_o;
    logic              ready_i;
    logic [7:0]        data_o;
    logic              flush_o;
    logic [DROP_W-1:0] drop_cnt_o;

    int checks = 0;
    int errors = 0;

    stream_flush_initiator #(
        .T           (logic [7:0]),
        .FlushCycles (FLUSH_CYCLES),
        .DropCntWidth(DROP_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .clr_i       (clr_i),
        .flush_req_i (flush_req_i),
        .flush_busy_o(flush_busy_o),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .data_i      (data_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .data_o      (data_o),
        .flush_o     (flush_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: one buffered beat, remaining flush cycles, and a saturating drop total.
    bit       m_full       = 1'b0;
    bit [7:0] m_data       = 8'h00;
    int       m_flush_left = 0;
    int       m_drops      = 0;

    function automatic bit exp_ready();
        return (m_flush_left == 0) && !flush_req_i && (!m_full || ready_i);
    endfunction

    always @(posedge clk or posedge rst_i) begin
        if (rst_i || clr_i) begin
            m_full       = 1'b0;
            m_data       = 8'h00;
            m_flush_left = 0;
            m_drops      = 0;
        end else if (m_flush_left != 0) begin
            m_flush_left = m_flush_left - 1;
        end else if (flush_req_i) begin
            if (m_full && !ready_i)
                m_drops = (m_drops + 1 > DROP_MAX) ? DROP_MAX : m_drops + 1;
            m_full       = 1'b0;
            m_flush_left = FLUSH_CYCLES;
        end else if (valid_i && exp_ready()) begin
            m_full = 1'b1;
            m_data = data_i;
        end else if (m_full && ready_i) begin
            m_full = 1'b0;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        bit idle;
        idle = (m_flush_left == 0);
        check_output("valid_o", 32'(valid_o), 32'(idle && m_full));
        check_output("ready_o", 32'(ready_o), 32'(exp_ready()));
        check_output("flush_o", 32'(flush_o), 32'(!idle));
        check_output("flush_busy_o", 32'(flush_busy_o), 32'(!idle || flush_req_i));
        check_output("drop_cnt_o", 32'(drop_cnt_o), DROP_EN ? 32'(m_drops) : 32'd0);
        check_output("flush_with_valid", 32'(flush_o && valid_o), 32'd0);
        if (idle && m_full)
            check_output("data_o", 32'(data_o), 32'(m_data));
    end

    task automatic apply_stimulus(input logic v, input logic [7:0] d, input logic rdy, input logic freq);
        valid_i     = v;
        data_i      = d;
        ready_i     = rdy;
        flush_req_i = freq;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Buffers one beat with the sink stalled, then pulses a flush and runs it to completion.
    task automatic stalled_flush(input logic [7:0] d, input int exp_drop);
        apply_stimulus(1'b1, d, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
        check_output("accept_ready", 32'(ready_o), 32'd0);
        check_output("accept_valid", 32'(valid_o), 32'd1);
        check_output("accept_data", 32'(data_o), 32'(d));
        tick();
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
        check_output("drop_after_flush", 32'(drop_cnt_o), DROP_EN ? 32'(exp_drop) : 32'd0);
        for (int i = 0; i < FLUSH_CYCLES; i++) begin
            check_output("flush_pulse", 32'(flush_o), 32'd1);
            check_output("flush_valid_low", 32'(valid_o), 32'd0);
            tick();
        end
        check_output("flush_done", 32'(flush_o), 32'd0);
        check_output("ready_after_flush", 32'(ready_o), 32'd1);
    endtask

    initial begin
        logic [10:0] flush_seen;
        logic [10:0] flush_exp;
        int          drop_seq [5];

        rst_i = 1'b1;
        clr_i = 1'b0;
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (2) tick();
        rst_i = 1'b0;
        tick();
        check_output("reset_valid", 32'(valid_o), 32'd0);
        check_output("reset_flush", 32'(flush_o), 32'd0);
        check_output("reset_busy", 32'(flush_busy_o), 32'd0);
        check_output("reset_ready", 32'(ready_o), 32'd1);
        check_output("reset_drop", 32'(drop_cnt_o), 32'd0);

        $display("[TB] streaming 8 beats");
        for (int k = 1; k <= 8; k++) begin
            apply_stimulus(1'b1, 8'(k), 1'b1, 1'b0);
            tick();
            check_output("stream_valid", 32'(valid_o), 32'd1);
            check_output("stream_data", 32'(data_o), 32'(k));
        end
        apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        check_output("stream_drained", 32'(valid_o), 32'd0);
        check_output("stream_drop", 32'(drop_cnt_o), 32'd0);

        $display("[TB] stalled flush");
        stalled_flush(8'hAA, 1);

        $display("[TB] clear then race flush");
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        check_output("clr_drop", 32'(drop_cnt_o), 32'd0);
        apply_stimulus(1'b1, 8'h55, 1'b1, 1'b0);
        tick();
        apply_stimulus(1'b0, 8'h00, 1'b1, 1'b1);
        check_output("race_valid", 32'(valid_o), 32'd1);
        check_output("race_data", 32'(data_o), 32'h55);
        tick();
        apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
        check_output("race_flush", 32'(flush_o), 32'd1);
        check_output("race_drop", 32'(drop_cnt_o), 32'd0);
        repeat (FLUSH_CYCLES) tick();

        $display("[TB] held flush request");
        flush_exp = 11'b00_1111_0_1111_0;
        apply_stimulus(1'b1, 8'h77, 1'b0, 1'b1);
        for (int c = 0; c < 11; c++) begin
            if (c == 10) apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
            flush_seen[c] = flush_o;
            tick();
        end
        check_output("held_pattern", 32'(flush_seen), {21'd0, flush_exp[0], flush_exp[1], flush_exp[2],
            flush_exp[3], flush_exp[4], flush_exp[5], flush_exp[6], flush_exp[7], flush_exp[8],
            flush_exp[9], flush_exp[10]});

        $display("[TB] drop counter saturation");
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        drop_seq = '{1, 2, 3, 3, 3};
        for (int i = 0; i < 5; i++) stalled_flush(8'(8'h10 + i), drop_seq[i]);

        $display("[TB] reset during flush");
        apply_stimulus(1'b1, 8'h99, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        check_output("mid_flush_on", 32'(flush_o), 32'd1);
        #1 rst_i = 1'b1;
        #1;
        check_output("abort_flush", 32'(flush_o), 32'd0);
        check_output("abort_valid", 32'(valid_o), 32'd0);
        tick();
        rst_i = 1'b0;
        tick();
        check_output("abort_ready", 32'(ready_o), 32'd1);
        check_output("abort_drop", 32'(drop_cnt_o), 32'd0);
        check_output("abort_idle", 32'(flush_o), 32'd0);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
